// File: rtl/pix_dump_pkg.sv
// Shared framing constants, widths and FSM encodings for the frame-buffer
// dump path, plus the pixel-to-byte split used by both pixel states.
package pix_dump_pkg;

    localparam logic [7:0] HDR0   = 8'hA5;
    localparam logic [7:0] HDR1   = 8'h5A;
    localparam int         PIX_W  = 12;
    localparam int         ADDR_W = 15;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_PHI  = 3'd4;
    localparam logic [2:0] ST_PLO  = 3'd5;
    localparam logic [2:0] ST_CKS  = 3'd6;
    localparam logic [2:0] ST_FIN  = 3'd7;

    // RGB444 goes out as {0,R} then {G,B}
    function automatic logic [7:0] pix_hi(input logic [PIX_W-1:0] p);
        return {4'h0, p[11:8]};
    endfunction

    function automatic logic [7:0] pix_lo(input logic [PIX_W-1:0] p);
        return p[7:0];
    endfunction

endpackage

// File: rtl/pix_dump_tx_pacer.sv
// Byte-interval down-counter: load starts a CYCLES-long interval, fire stays
// high once it has elapsed until the next load or clear.
module tx_pacer #(
    parameter int CYCLES = 120
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic clear_i,
    output logic fire_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;

    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (clear_i) begin
            cnt_d   = '0;
            armed_d = 1'b0;
        end else if (load_i) begin
            cnt_d   = CW'(CYCLES - 1);
            armed_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign fire_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/pix_dump.sv
// Frame-buffer readback transmitter: header, raster-order RGB444 pixels as
// two bytes each, then an 8-bit checksum, paced at one byte per BYTE_CYCLES.
module pix_dump
    import pix_dump_pkg::*;
#(
    parameter int W         = 50,
    parameter int H         = 40,
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY_ON = 0,
    parameter int GAP_BITS  = 2
) (
    input  logic              i_clk_sys,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid
);

    localparam int BYTE_CYCLES = (CLK_FRE * 1000000 / BAUD_RATE) * (10 + PARITY_ON + GAP_BITS);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(W * H - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        hdr_q, hdr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [7:0]        cks_q, cks_d;
    logic [7:0]        txd_q, txd_d;
    logic              txv_q, txv_d;
    logic              done_q, done_d;
    logic              fire, load, clear;

    tx_pacer #(.CYCLES(BYTE_CYCLES)) u_pacer (
        .clk_i   (i_clk_sys),
        .rst_i   (i_rst),
        .load_i  (load),
        .clear_i (clear),
        .fire_o  (fire)
    );

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        addr_d  = addr_q;
        pix_d   = pix_q;
        cks_d   = cks_q;
        txd_d   = txd_q;
        txv_d   = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        // abort beats everything, including a start seen in the same cycle
        if (i_abort) begin
            state_d = ST_IDLE;
            clear   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) begin
                    state_d = ST_HDR;
                    hdr_d   = 2'd1;
                    addr_d  = '0;
                    cks_d   = '0;
                    txd_d   = HDR0;
                    txv_d   = 1'b1;
                    load    = 1'b1;
                end
                ST_HDR: if (fire) begin
                    txv_d = 1'b1;
                    load  = 1'b1;
                    case (hdr_q)
                        2'd1:    txd_d = HDR1;
                        2'd2:    txd_d = 8'(W);
                        default: txd_d = 8'(H);
                    endcase
                    if (hdr_q == 2'd3) state_d = ST_RD;
                    else               hdr_d   = hdr_q + 2'd1;
                end
                ST_RD:  state_d = ST_CAP;
                ST_CAP: begin
                    pix_d   = i_rd_data;
                    state_d = ST_PHI;
                end
                ST_PHI: if (fire) begin
                    txd_d   = pix_hi(pix_q);
                    cks_d   = cks_q + pix_hi(pix_q);
                    txv_d   = 1'b1;
                    load    = 1'b1;
                    state_d = ST_PLO;
                end
                ST_PLO: if (fire) begin
                    txd_d = pix_lo(pix_q);
                    cks_d = cks_q + pix_lo(pix_q);
                    txv_d = 1'b1;
                    load  = 1'b1;
                    // the next read lands in the gap after this byte
                    if (addr_q == LAST_PIX) begin
                        state_d = ST_CKS;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_RD;
                    end
                end
                ST_CKS: if (fire) begin
                    txd_d   = cks_q;
                    txv_d   = 1'b1;
                    load    = 1'b1;
                    state_d = ST_FIN;
                end
                ST_FIN: if (fire) begin
                    done_d  = 1'b1;
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            hdr_q   <= '0;
            addr_q  <= '0;
            pix_q   <= '0;
            cks_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            addr_q  <= addr_d;
            pix_q   <= pix_d;
            cks_q   <= cks_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            done_q  <= done_d;
        end
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = done_q;
    assign o_rd_en    = (state_q == ST_RD);
    assign o_rd_addr  = addr_q;
    assign o_tx_data  = txd_q;
    assign o_tx_valid = txv_q;

endmodule

// File: tb/tb_pix_dump.sv
// Bench for pix_dump: random and fixed image contents checked against a
// byte-stream model, plus abort, reset, re-start and start+abort cases.
module tb_pix_dump;

    localparam int TW   = 3;
    localparam int TH   = 2;
    localparam int NPIX = TW * TH;
    localparam int BC   = 120;

    logic        clk = 1'b0;
    logic        rst, start, abrt;
    logic        busy, done, rd_en, tx_valid;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic [7:0]  tx_data;

    logic [11:0] ram [0:NPIX-1];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        busy_at_done;

    logic [7:0] vq[$];
    int         tq[$];
    int         aq[$];
    int         dq[$];

    always #5 clk = ~clk;

    pix_dump #(
        .W(TW), .H(TH), .CLK_FRE(1), .BAUD_RATE(100000), .PARITY_ON(0), .GAP_BITS(2)
    ) dut (
        .i_clk_sys  (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_abort    (abrt),
        .o_busy     (busy),
        .o_done     (done),
        .o_rd_en    (rd_en),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= (int'(rd_addr) < NPIX) ? ram[rd_addr] : 12'hBAD;
    end

    always @(negedge clk) begin
        if (tx_valid) begin
            vq.push_back(tx_data);
            tq.push_back(cyc);
        end
        if (rd_en) aq.push_back(int'(rd_addr));
        if (done) begin
            dq.push_back(cyc);
            busy_at_done = busy;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        vq.delete(); tq.delete(); aq.delete(); dq.delete();
    endtask

    task automatic run_dump(input bit repulse);
        logic [7:0] exp[$];
        int sum = 0;
        int t0;
        exp.push_back(8'hA5);
        exp.push_back(8'h5A);
        exp.push_back(8'(TW));
        exp.push_back(8'(TH));
        for (int i = 0; i < NPIX; i++) begin
            exp.push_back(8'(ram[i] / 256));
            exp.push_back(8'(ram[i] % 256));
            sum += ram[i] / 256 + ram[i] % 256;
        end
        exp.push_back(8'(sum % 256));
        clr_mon();
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < exp.size() * BC + 400 && dq.size() == 0; k++) begin
            start = (repulse && k == 300);
            step();
        end
        start = 1'b0;
        chk("done_seen", dq.size(), 1);
        chk("byte_count", vq.size(), exp.size());
        for (int i = 0; i < vq.size() && i < exp.size(); i++)
            chk($sformatf("byte%0d", i), vq[i], exp[i]);
        if (tq.size() > 0) chk("first_latency", tq[0] - t0, 1);
        for (int i = 1; i < tq.size(); i++)
            chk($sformatf("gap%0d", i), tq[i] - tq[i-1], BC);
        if (dq.size() > 0 && tq.size() > 0) begin
            chk("done_gap", dq[0] - tq[tq.size()-1], BC);
            chk("busy_at_done", busy_at_done, 0);
        end
        chk("rd_count", aq.size(), NPIX);
        for (int i = 0; i < aq.size(); i++)
            chk($sformatf("rd_addr%0d", i), aq[i], i);
    endtask

    task automatic start_and_wait_bytes(input int nbytes);
        clr_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < (nbytes + 1) * BC && vq.size() < nbytes; k++) step();
        chk("reach_bytes", vq.size(), nbytes);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abrt = 1'b0;
        for (int i = 0; i < NPIX; i++) ram[i] = '0;
        step(); step();
        chk("reset_outs", {busy, done, rd_en, rd_addr, tx_data, tx_valid}, 0);
        rst = 1'b0;
        step();

        // fixed patterns
        ram[0] = 12'h123; ram[1] = 12'hABC;
        for (int i = 2; i < NPIX; i++) ram[i] = 12'(i * 12'h111);
        run_dump(1'b0);
        for (int i = 0; i < NPIX; i++) ram[i] = 12'hFFF;
        run_dump(1'b0);
        if (vq.size() > 0) chk("cks_all_fff", vq[vq.size()-1], 8'h54);

        // random images, some with a stray start mid-dump
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NPIX; i++) ram[i] = 12'($urandom);
            run_dump(r[0]);
        end

        // abort three cycles after the sixth byte
        start_and_wait_bytes(6);
        step(); step();
        abrt = 1'b1;
        step();
        abrt = 1'b0;
        chk("abort_busy", busy, 0);
        n = vq.size();
        for (int k = 0; k < 600; k++) step();
        chk("abort_bytes", vq.size(), 6);
        chk("abort_quiet", vq.size(), n);
        chk("abort_nodone", dq.size(), 0);
        for (int i = 0; i < NPIX; i++) ram[i] = 12'($urandom);
        run_dump(1'b0);

        // reset mid-dump
        start_and_wait_bytes(7);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("rst_mid_outs", {busy, done, rd_en, rd_addr, tx_data, tx_valid}, 0);
        rst = 1'b0;
        step();
        run_dump(1'b0);

        // start and abort together while idle
        clr_mon();
        start = 1'b1; abrt = 1'b1;
        step();
        start = 1'b0; abrt = 1'b0;
        chk("start_abort_busy", busy, 0);
        for (int k = 0; k < 300; k++) step();
        chk("start_abort_bytes", vq.size(), 0);
        chk("start_abort_done", dq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
